// File: rtl/layer_compositor_if.sv
// Pixel-stream bundle between the renderers, the layer compositor and the VGA pins.
// master drives the layer/bg/sync/mask inputs; slave is the compositor.
interface layer_compositor_if #(
  parameter int LAYERS     = 4,
  parameter int COLOR_BITS = 6
);
  logic                         i_hsync;
  logic                         i_vsync;
  logic                         i_visible;
  logic [9:0]                   i_hpos;
  logic [LAYERS-1:0]            i_layer_en;
  logic [LAYERS*COLOR_BITS-1:0] i_layer_rgb;
  logic [COLOR_BITS-1:0]        i_bg_lo;
  logic [COLOR_BITS-1:0]        i_bg_hi;
  logic                         i_mask_wr;
  logic [LAYERS-1:0]            i_mask;
  logic [LAYERS-1:0]            i_blink;
  logic                         i_frame_end;
  logic                         o_hsync_n;
  logic                         o_vsync_n;
  logic [COLOR_BITS-1:0]        o_rgb;
  logic [2:0]                   o_layer_id;

  modport master (
    output i_hsync, i_vsync, i_visible, i_hpos, i_layer_en, i_layer_rgb,
           i_bg_lo, i_bg_hi, i_mask_wr, i_mask, i_blink, i_frame_end,
    input  o_hsync_n, o_vsync_n, o_rgb, o_layer_id
  );
  modport slave (
    input  i_hsync, i_vsync, i_visible, i_hpos, i_layer_en, i_layer_rgb,
           i_bg_lo, i_bg_hi, i_mask_wr, i_mask, i_blink, i_frame_end,
    output o_hsync_n, o_vsync_n, o_rgb, o_layer_id
  );
endinterface

// File: rtl/layer_compositor.sv
// Priority compositor: LAYERS overlay channels over a split floor/sky background,
// with frame-synchronous enable/blink masks and a PIPE-deep aligned output pipeline.
module layer_compositor #(
  parameter int LAYERS     = 4,
  parameter int COLOR_BITS = 6,
  parameter int PIPE       = 2,
  parameter int HALF_SIZE  = 320
) (
  input logic              clk,
  input logic              reset,
  layer_compositor_if.slave bus
);
  typedef struct packed {
    logic                  hs_n;
    logic                  vs_n;
    logic [COLOR_BITS-1:0] rgb;
    logic [2:0]            id;
  } pix_t;

  localparam pix_t PIX_RST = '{hs_n: 1'b1, vs_n: 1'b1, rgb: '0, id: 3'd7};

  logic [LAYERS-1:0]     r_pend_mask, r_pend_blink;
  logic [LAYERS-1:0]     r_act_mask, r_act_blink;
  logic [5:0]            r_frame_cnt;
  logic                  r_vsync_d;
  pix_t                  r_pipe [PIPE];

  logic [LAYERS-1:0]     w_elig;
  logic                  w_hit;
  logic [2:0]            w_win_id;
  logic [COLOR_BITS-1:0] w_win_rgb;
  pix_t                  w_stage0;

  // A coincident write and commit takes the fresh values straight into the active set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_mask  <= '1;
      r_pend_blink <= '0;
      r_act_mask   <= '1;
      r_act_blink  <= '0;
    end else begin
      if (bus.i_mask_wr) begin
        r_pend_mask  <= bus.i_mask;
        r_pend_blink <= bus.i_blink;
      end
      if (bus.i_frame_end) begin
        r_act_mask  <= bus.i_mask_wr ? bus.i_mask  : r_pend_mask;
        r_act_blink <= bus.i_mask_wr ? bus.i_blink : r_pend_blink;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_d <= bus.i_vsync;
      if (bus.i_vsync && !r_vsync_d)
        r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  assign w_elig = bus.i_layer_en & r_act_mask & ~(r_act_blink & {LAYERS{r_frame_cnt[5]}});

  always_comb begin
    w_hit     = 1'b0;
    w_win_id  = 3'd7;
    w_win_rgb = '0;
    // Walk from lowest priority upward so the lowest eligible index lands last.
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_hit     = 1'b1;
        w_win_id  = 3'(k);
        w_win_rgb = bus.i_layer_rgb[k*COLOR_BITS +: COLOR_BITS];
      end
    end
  end

  always_comb begin
    w_stage0.hs_n = ~bus.i_hsync;
    w_stage0.vs_n = ~bus.i_vsync;
    w_stage0.rgb  = '0;
    w_stage0.id   = 3'd7;
    if (bus.i_visible) begin
      if (w_hit) begin
        w_stage0.rgb = w_win_rgb;
        w_stage0.id  = w_win_id;
      end else begin
        w_stage0.rgb = (bus.i_hpos < 10'(HALF_SIZE)) ? bus.i_bg_lo : bus.i_bg_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) r_pipe[i] <= PIX_RST;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign bus.o_hsync_n  = r_pipe[PIPE-1].hs_n;
  assign bus.o_vsync_n  = r_pipe[PIPE-1].vs_n;
  assign bus.o_rgb      = r_pipe[PIPE-1].rgb;
  assign bus.o_layer_id = r_pipe[PIPE-1].id;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: three instances (PIPE=1,2,3) share one stimulus;
// most checks use the PIPE=2 instance, the sync/pixel alignment sweep uses all three.
module tb_layer_compositor;
  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync, visible, mask_wr, frame_end;
  logic [9:0]  hpos;
  logic [3:0]  layer_en, mask, blink;
  logic [23:0] layer_rgb;
  logic [5:0]  bg_lo, bg_hi;

  logic [3:1][5:0] o_rgb_a;
  logic [3:1][2:0] o_id_a;
  logic [3:1]      o_hs_a, o_vs_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar p = 1; p <= 3; p++) begin : g_dut
    layer_compositor_if #(.LAYERS(4), .COLOR_BITS(6)) bus ();
    assign bus.i_hsync     = hsync;
    assign bus.i_vsync     = vsync;
    assign bus.i_visible   = visible;
    assign bus.i_hpos      = hpos;
    assign bus.i_layer_en  = layer_en;
    assign bus.i_layer_rgb = layer_rgb;
    assign bus.i_bg_lo     = bg_lo;
    assign bus.i_bg_hi     = bg_hi;
    assign bus.i_mask_wr   = mask_wr;
    assign bus.i_mask      = mask;
    assign bus.i_blink     = blink;
    assign bus.i_frame_end = frame_end;
    layer_compositor #(.LAYERS(4), .COLOR_BITS(6), .PIPE(p), .HALF_SIZE(320)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    assign o_rgb_a[p] = bus.o_rgb;
    assign o_id_a[p]  = bus.o_layer_id;
    assign o_hs_a[p]  = bus.o_hsync_n;
    assign o_vs_a[p]  = bus.o_vsync_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; tick(1);
      vsync = 1'b0; tick(1);
    end
  endtask

  logic [3:0][5:0] rec_rgb;
  logic [3:0][2:0] rec_id;
  logic [3:0]      rec_hs;

  initial begin
    reset = 1'b1;
    hsync = 1'b0; vsync = 1'b0; visible = 1'b1; hpos = 10'd0;
    layer_en = 4'b1111; layer_rgb = {6'h04, 6'h03, 6'h02, 6'h01};
    bg_lo = 6'h15; bg_hi = 6'h2A;
    mask_wr = 1'b0; mask = 4'b1111; blink = 4'b0000; frame_end = 1'b0;

    tick(3);
    chk("rst_rgb", 32'(o_rgb_a[2]), 32'h0);
    chk("rst_hs",  32'(o_hs_a[2]),  32'h1);
    chk("rst_vs",  32'(o_vs_a[2]),  32'h1);
    chk("rst_id",  32'(o_id_a[2]),  32'h7);

    reset = 1'b0;
    tick(2);
    chk("post_rst_id",  32'(o_id_a[2]),  32'h0);
    chk("post_rst_rgb", 32'(o_rgb_a[2]), 32'h01);

    // Background split, back-to-back pixels to pin exact latency
    layer_en = 4'b0000; hpos = 10'd319;
    tick(1);
    hpos = 10'd320;
    tick(1);
    chk("bg_lo_319", 32'(o_rgb_a[2]), 32'h15);
    chk("bg_id",     32'(o_id_a[2]),  32'h7);
    tick(1);
    chk("bg_hi_320", 32'(o_rgb_a[2]), 32'h2A);

    // Pending mask must not take effect before frame_end
    layer_en = 4'b1111;
    mask_wr = 1'b1; mask = 4'b1110; blink = 4'b0000;
    tick(1);
    mask_wr = 1'b0;
    tick(2);
    chk("pend_no_effect", 32'(o_id_a[2]), 32'h0);
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0; layer_en = 4'b0011;
    tick(2);
    chk("commit_id",  32'(o_id_a[2]),  32'h1);
    chk("commit_rgb", 32'(o_rgb_a[2]), 32'h02);

    // Coincident write + commit bypasses pending
    mask_wr = 1'b1; frame_end = 1'b1; mask = 4'b0000;
    tick(1);
    mask_wr = 1'b0; frame_end = 1'b0; layer_en = 4'b1111;
    tick(2);
    chk("bypass_id",  32'(o_id_a[2]),  32'h7);
    chk("bypass_rgb", 32'(o_rgb_a[2]), 32'h2A);

    // Blink on layer 0
    mask_wr = 1'b1; frame_end = 1'b1; mask = 4'b1111; blink = 4'b0001;
    tick(1);
    mask_wr = 1'b0; frame_end = 1'b0; layer_en = 4'b0011;
    tick(2);
    chk("blink_f0", 32'(o_id_a[2]), 32'h0);
    vsync = 1'b1;
    tick(2);
    chk("vsync_n_delay", 32'(o_vs_a[2]), 32'h0);
    vsync = 1'b0;
    tick(1);
    vs_pulses(30);
    tick(2);
    chk("blink_f31", 32'(o_id_a[2]), 32'h0);
    vs_pulses(1);
    tick(2);
    chk("blink_f32_id",  32'(o_id_a[2]),  32'h1);
    chk("blink_f32_rgb", 32'(o_rgb_a[2]), 32'h02);
    vs_pulses(31);
    tick(2);
    chk("blink_f63", 32'(o_id_a[2]), 32'h1);
    vs_pulses(1);
    tick(2);
    chk("blink_f64", 32'(o_id_a[2]), 32'h0);

    // Blanking wins over any layer
    visible = 1'b0; layer_en = 4'b1111;
    tick(2);
    chk("blank_rgb", 32'(o_rgb_a[2]), 32'h0);
    chk("blank_id",  32'(o_id_a[2]),  32'h7);
    visible = 1'b1;

    // Alignment sweep: hsync pulse and one-pixel layer-0 hit together
    layer_en = 4'b0000; hpos = 10'd320;
    tick(4);
    hsync = 1'b1; layer_en = 4'b0001;
    for (int e = 0; e < 4; e++) begin
      tick(1);
      if (e == 0) begin hsync = 1'b0; layer_en = 4'b0000; end
      for (int p = 1; p <= 3; p++) begin
        if (e + 1 == p) begin
          chk($sformatf("sweep_p%0d_hs", p),  32'(o_hs_a[p]),  32'h0);
          chk($sformatf("sweep_p%0d_id", p),  32'(o_id_a[p]),  32'h0);
          chk($sformatf("sweep_p%0d_rgb", p), 32'(o_rgb_a[p]), 32'h01);
        end else begin
          chk($sformatf("sweep_p%0d_e%0d_hs", p, e + 1), 32'(o_hs_a[p]), 32'h1);
          chk($sformatf("sweep_p%0d_e%0d_id", p, e + 1), 32'(o_id_a[p]), 32'h7);
        end
      end
    end

    // Asynchronous reset mid-frame, no clock edge needed
    layer_en = 4'b1111; hsync = 1'b1;
    tick(3);
    chk("pre_areset_id", 32'(o_id_a[2]), 32'h0);
    reset = 1'b1;
    #2;
    chk("areset_rgb", 32'(o_rgb_a[2]), 32'h0);
    chk("areset_id",  32'(o_id_a[2]),  32'h7);
    chk("areset_hs",  32'(o_hs_a[2]),  32'h1);
    chk("areset_p3",  32'(o_rgb_a[3]), 32'h0);
    tick(2);
    chk("areset_hold", 32'(o_rgb_a[2]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
